// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding and word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHK   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words and flags the byte that completes a word.
// Latency: combinational word_dat/word_ready on the completing byte; 3 earlier bytes are registered.
// Backpressure: none of its own; it only shifts on byte_acc, which the caller gates.
module loader_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_acc,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word_dat
);

    logic [23:0]       shift_q;
    logic [BCNT_W-1:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (byte_acc) begin
            shift_q  <= {shift_q[15:0], byte_in};
            // Wraps back to 0 after the fourth byte, ready for the next word.
            byte_cnt <= byte_cnt + BCNT_W'(1);
        end
    end

    assign word_ready = byte_acc && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign word_dat   = {shift_q, byte_in};

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program byte stream into instruction memory as big-endian words at 0,4,8,...; optional checksum via LOADER_CHECKSUM_EN.
// Latency: 4 accepted bytes + 1 write cycle per word (5 cycles/word with byte_valid held high).
// Backpressure: byte_ready only in RECV (and CHK); the fetch stage is stalled while busy.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load_len,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             cpu_stall,
    output logic             done,
    output logic             len_err,
    output logic             chk_err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] word_idx, len_q;
    logic             start_acc, byte_acc, word_ready, last_word;
    logic [31:0]      word_dat;

    assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign byte_acc  = byte_valid && byte_ready;
    assign last_word = (word_idx == len_q - CNT_W'(1));

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc),
        .byte_acc   (byte_acc && state_q == S_RECV),
        .byte_in    (byte_in),
        .word_ready (word_ready),
        .word_dat   (word_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_idx  <= '0;
            len_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                word_idx <= '0;
                len_q    <= load_len;
            end
            // Address/data are captured on the completing byte so they are stable through WRITE.
            if (state_q == S_RECV && word_ready) begin
                mem_addr  <= WIDTH'({word_idx, 2'b00});
                mem_wdata <= WIDTH'(word_dat);
            end
            if (state_q == S_WRITE && !last_word)
                word_idx <= word_idx + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (load_len > DEPTH_C)
                        state_d = S_ERROR;
                    else if (load_len == '0)
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    else
                        state_d = S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_ready)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (last_word)
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                else
                    state_d = S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid)
                    state_d = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_stall = busy;
    assign done      = (state_q == S_DONE);
    assign len_err   = (state_q == S_ERROR);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       chk_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else if (start_acc) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else if (byte_acc && state_q == S_RECV) begin
            sum_q <= sum_q + byte_in;
        end else if (byte_acc && state_q == S_CHK) begin
            chk_err_q <= (byte_in != sum_q);
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset, streaming loads, stalls, length errors, full depth, abort.
// Latency: n/a.
// Backpressure: bytes are offered and held until byte_ready is seen.
module tb_instr_mem_loader;

    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] load_len = '0;
    logic [7:0]       byte_in = '0;
    logic             byte_valid = 1'b0;
    logic             byte_ready, mem_we, busy, cpu_stall, done, len_err, chk_err;
    logic [31:0]      mem_addr, mem_wdata;

    instr_mem_loader #(.WIDTH(32), .DEPTH(100), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_stall  (cpu_stall),
        .done       (done),
        .len_err    (len_err),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_n     = 0;
    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int          wr_cyc  [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_n < 256) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic do_start(input logic [CNT_W-1:0] len);
        start    = 1'b1;
        load_len = len;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        byte_in    = b;
        byte_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
        end
        n_checks++;
        if (k == 50) begin
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h never accepted within 50 cycles", b);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done, len_err, chk_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h data=%h busy=%b stall=%b done=%b len_err=%b chk_err=%b, required all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done, len_err, chk_err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int base;
        base = wr_n;
        do_start(7'd2);
        n_checks++;
        if ({busy, cpu_stall, byte_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL basic_busy: busy/stall/ready=%b required 111", {busy, cpu_stall, byte_ready});
        end
        send_word(32'h8C010004);
        send_word(32'h20020005);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB8);
`endif
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wr_n - base !== 2) begin
            n_fail++; $display("FAIL basic_wr_count: got %0d required 2", wr_n - base);
        end
        n_checks++;
        if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h8C010004) begin
            n_fail++; $display("FAIL basic_wr0: got %h/%h required 00000000/8c010004", wr_addr[base], wr_data[base]);
        end
        n_checks++;
        if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h20020005) begin
            n_fail++; $display("FAIL basic_wr1: got %h/%h required 00000004/20020005", wr_addr[base+1], wr_data[base+1]);
        end
        n_checks++;
        if (wr_cyc[base+1] - wr_cyc[base] !== 5) begin
            n_fail++; $display("FAIL basic_throughput: got %0d cycles/word required 5", wr_cyc[base+1] - wr_cyc[base]);
        end
        n_checks++;
        if ({done, busy, cpu_stall, byte_ready, len_err, chk_err} !== 6'b100000) begin
            n_fail++; $display("FAIL basic_done: done/busy/stall/ready/len_err/chk_err=%b required 100000",
                               {done, busy, cpu_stall, byte_ready, len_err, chk_err});
        end
    endtask

    task automatic test_stall;
        int base;
        int bad_rdy;
        base = wr_n;
        bad_rdy = 0;
        do_start(7'd2);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL stall_done_clear: got %b required 0", done);
        end
        send_byte(8'h8C);
        send_byte(8'h01);
        byte_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (byte_ready !== 1'b1 || mem_we !== 1'b0) bad_rdy++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad_rdy !== 0) begin
            n_fail++; $display("FAIL stall_ready_hold: %0d idle cycles without ready or with a write, required 0", bad_rdy);
        end
        send_byte(8'h00);
        send_byte(8'h04);
        send_word(32'h20020005);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB8);
`endif
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wr_n - base !== 2 || wr_data[base] !== 32'h8C010004 || wr_data[base+1] !== 32'h20020005
            || wr_addr[base+1] !== 32'h4) begin
            n_fail++; $display("FAIL stall_writes: count=%0d d0=%h d1=%h a1=%h required 2/8c010004/20020005/00000004",
                               wr_n - base, wr_data[base], wr_data[base+1], wr_addr[base+1]);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_done: done=%b busy=%b required 1/0", done, busy);
        end
    endtask

    task automatic test_len_err;
        int base;
        int rdy_seen;
        base = wr_n;
        rdy_seen = 0;
        byte_in = 8'hFF;
        byte_valid = 1'b1;
        do_start(7'd101);
        repeat (6) begin
            @(negedge clk);
            if (byte_ready !== 1'b0) rdy_seen++;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        n_checks++;
        if ({len_err, done, busy, cpu_stall} !== 4'b1000) begin
            n_fail++; $display("FAIL len_err_flags: len_err/done/busy/stall=%b required 1000", {len_err, done, busy, cpu_stall});
        end
        n_checks++;
        if (wr_n - base !== 0 || rdy_seen !== 0) begin
            n_fail++; $display("FAIL len_err_quiet: writes=%0d ready_cycles=%0d required 0/0", wr_n - base, rdy_seen);
        end
    endtask

    task automatic test_len_zero;
        int base;
        base = wr_n;
        do_start(7'd0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
        byte_valid = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, len_err, busy, chk_err} !== 4'b1000) begin
            n_fail++; $display("FAIL len_zero_flags: done/len_err/busy/chk_err=%b required 1000", {done, len_err, busy, chk_err});
        end
        n_checks++;
        if (wr_n - base !== 0) begin
            n_fail++; $display("FAIL len_zero_writes: got %0d required 0", wr_n - base);
        end
    endtask

    task automatic test_full_depth;
        int base;
        int bad;
        logic [7:0] sum;
        base = wr_n;
        bad = 0;
        sum = 8'h00;
        do_start(7'd100);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                byte_valid = 1'b0;
                do_start(7'd3);
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL full_ignored_start: busy=%b required 1", busy);
                end
            end
            send_word(32'hA5000000 + 32'(i));
            sum = sum + 8'hA5 + 8'(i);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wr_n - base !== 100) begin
            n_fail++; $display("FAIL full_wr_count: got %0d required 100", wr_n - base);
        end
        n_checks++;
        if (wr_addr[base+99] !== 32'h18C || wr_data[base+99] !== 32'hA5000063) begin
            n_fail++; $display("FAIL full_last_write: got %h/%h required 0000018c/a5000063", wr_addr[base+99], wr_data[base+99]);
        end
        for (int i = 0; i < 100; i++)
            if (wr_addr[base+i] !== 32'(i * 4) || wr_data[base+i] !== 32'hA5000000 + 32'(i)) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL full_sequence: %0d writes with wrong addr/data, required 0", bad);
        end
        n_checks++;
        if (done !== 1'b1 || chk_err !== 1'b0) begin
            n_fail++; $display("FAIL full_done: done=%b chk_err=%b required 1/0", done, chk_err);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        do_start(7'd1);
        send_word(32'h01020304);
        @(posedge clk); #1;
        n_checks++;
        if ({byte_ready, busy, done} !== 3'b110) begin
            n_fail++; $display("FAIL chk_wait: ready/busy/done=%b required 110", {byte_ready, busy, done});
        end
        send_byte(8'h0A);
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (chk_err !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL chk_good: chk_err=%b done=%b required 0/1", chk_err, done);
        end
        do_start(7'd1);
        send_word(32'h01020304);
        send_byte(8'h0B);
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (chk_err !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL chk_bad: chk_err=%b done=%b required 1/1", chk_err, done);
        end
    endtask
`endif

    task automatic test_reset_mid_load;
        int base;
        base = wr_n;
        do_start(7'd3);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done, len_err, chk_err} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: ready=%b we=%b addr=%h data=%h busy=%b stall=%b done=%b, required all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        byte_in = 8'h77;
        repeat (10) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        n_checks++;
        if (wr_n - base !== 1 || wr_data[base] !== 32'h11223344) begin
            n_fail++; $display("FAIL abort_writes: count=%0d d0=%h required 1/11223344", wr_n - base, wr_data[base]);
        end
        n_checks++;
        if ({byte_ready, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL abort_idle: ready/busy/done=%b required 000", {byte_ready, busy, done});
        end
    endtask

    initial begin
        #12;
        test_reset;
        test_basic;
        test_stall;
        test_len_err;
        test_len_zero;
        test_full_depth;
`ifdef LOADER_CHECKSUM_EN
        test_checksum;
`endif
        test_reset_mid_load;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
